// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: store strobes/enables, load lane extract+extend, MEM/WB register.
// Store write is combinational toward the memory; load data and exceptions register after 1 cycle.
// stall holds the MEM/WB register and blocks the store; flush kills the instruction.
module mem_lsu #(
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic        is_sw_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] dm_dout,
    output logic [11:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_din,
    output logic        dm_we,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic [1:0]  exc_o,
    output logic [31:0] badaddr_o
);

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_OOR  = 2'd3;

    localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS);

    logic        is_load;
    logic        is_store;
    logic        sz_byte;
    logic        sz_half;
    logic        misalign;
    logic        out_of_range;
    logic [1:0]  exc;
    logic [3:0]  be;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;

    assign dm_addr = addr_i[13:2];
    assign dm_din  = wdata_i;

    // Decode operation class and access size; is_sw_i wins over op_i.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        if (is_sw_i) begin
            is_store = 1'b1;
        end else begin
            case (op_i)
                OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
                OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
                OP_LW:         begin is_load  = 1'b1;                 end
                OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
                OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
                default:       ;
            endcase
        end
    end

    // Address checks; misalignment outranks the range fault.
    always_comb begin
        misalign     = sz_byte ? 1'b0 : (sz_half ? addr_i[0] : (addr_i[1:0] != 2'b00));
        out_of_range = (addr_i[31:14] != 18'd0) || ({20'd0, addr_i[13:2]} >= DM_LIMIT);
        exc          = EXC_NONE;
        if (valid_i && (is_load || is_store)) begin
            if (misalign)
                exc = is_store ? EXC_ADES : EXC_ADEL;
            else if (out_of_range)
                exc = EXC_OOR;
        end
    end

    // Byte enables for the store size; gated to zero whenever no write fires.
    always_comb begin
        be = 4'b0000;
        if (sz_byte)
            be = 4'b0001 << addr_i[1:0];
        else if (sz_half)
            be = addr_i[1] ? 4'b1100 : 4'b0011;
        else
            be = 4'b1111;
        dm_we = valid_i && is_store && !stall && !flush && !rst && (exc == EXC_NONE);
        dm_be = dm_we ? be : 4'b0000;
    end

    // Little-endian lane select followed by sign or zero extension.
    always_comb begin
        lane_h = addr_i[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (addr_i[1:0])
            2'd0:    lane_b = dm_dout[7:0];
            2'd1:    lane_b = dm_dout[15:8];
            2'd2:    lane_b = dm_dout[23:16];
            default: lane_b = dm_dout[31:24];
        endcase
        ld_data = 32'd0;
        if (is_load) begin
            case (op_i)
                OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
                OP_LBU:  ld_data = {24'd0, lane_b};
                OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
                OP_LHU:  ld_data = {16'd0, lane_h};
                default: ld_data = dm_dout;
            endcase
        end
    end

    // MEM/WB register: reset clears, stall holds, flush inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o   <= 1'b0;
            rdata_o   <= 32'd0;
            exc_o     <= EXC_NONE;
            badaddr_o <= 32'd0;
        end else if (!stall) begin
            if (flush) begin
                valid_o   <= 1'b0;
                rdata_o   <= 32'd0;
                exc_o     <= EXC_NONE;
                badaddr_o <= 32'd0;
            end else begin
                valid_o   <= valid_i;
                rdata_o   <= (valid_i && is_load) ? ld_data : 32'd0;
                exc_o     <= exc;
                badaddr_o <= (exc != EXC_NONE) ? addr_i : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a byte-lane-aware data memory model.
// Each vector checks the combinational store side, then the registered WB side one edge later.
// Hand sequences cover stall hold, flush during stall, and reset with a store pending.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_i, is_sw_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i, wdata_i, dm_dout;
    logic [11:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic [1:0]  exc_o;
    logic [31:0] badaddr_o;

    logic [31:0] mem [0:4095];
    logic        mem_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu #(.DM_WORDS(3072)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_i(valid_i), .op_i(op_i), .is_sw_i(is_sw_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .dm_dout(dm_dout),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_we(dm_we),
        .rdata_o(rdata_o), .valid_o(valid_o), .exc_o(exc_o), .badaddr_o(badaddr_o)
    );

    // Memory model: unshifted data placed into lanes according to the enable pattern.
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
        end else if (dm_we) begin
            case (dm_be)
                4'b1111: mem[dm_addr]        <= dm_din;
                4'b0011: mem[dm_addr][15:0]  <= dm_din[15:0];
                4'b1100: mem[dm_addr][31:16] <= dm_din[15:0];
                4'b0001: mem[dm_addr][7:0]   <= dm_din[7:0];
                4'b0010: mem[dm_addr][15:8]  <= dm_din[7:0];
                4'b0100: mem[dm_addr][23:16] <= dm_din[7:0];
                4'b1000: mem[dm_addr][31:24] <= dm_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic        f;
        logic [2:0]  op;
        logic        sw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [3:0]  be;
        logic        vo;
        logic [31:0] rd;
        logic [1:0]  exc;
        logic [31:0] bad;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input logic v, input logic f, input logic [2:0] op, input logic sw,
                         input logic [31:0] addr, input logic [31:0] wd);
        valid_i = v; flush = f; op_i = op; is_sw_i = sw; addr_i = addr; wdata_i = wd;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; stall = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 1'b1, 32'h0, 32'hFFFF_FFFF);

        //            v  f  op    sw  addr          wdata         we be     vo rdata         exc bad
        vq.push_back('{1, 0, 3'd6, 0, 32'h00000003, 32'h000000A5, 1, 4'h8, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd2, 0, 32'h00000003, 32'h00000000, 0, 4'h0, 1, 32'h000000A5, 0, 32'h0});
        vq.push_back('{1, 0, 3'd1, 0, 32'h00000003, 32'h00000000, 0, 4'h0, 1, 32'hFFFFFFA5, 0, 32'h0});
        vq.push_back('{1, 0, 3'd7, 0, 32'h00000002, 32'h00008001, 1, 4'hC, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd3, 0, 32'h00000002, 32'h00000000, 0, 4'h0, 1, 32'hFFFF8001, 0, 32'h0});
        vq.push_back('{1, 0, 3'd4, 0, 32'h00000002, 32'h00000000, 0, 4'h0, 1, 32'h00008001, 0, 32'h0});
        vq.push_back('{1, 0, 3'd5, 0, 32'h00000005, 32'h00000000, 0, 4'h0, 1, 32'h00000000, 1, 32'h5});
        vq.push_back('{1, 0, 3'd7, 0, 32'h00000001, 32'h0000FFFF, 0, 4'h0, 1, 32'h00000000, 2, 32'h1});
        vq.push_back('{1, 0, 3'd5, 0, 32'h00000000, 32'h00000000, 0, 4'h0, 1, 32'h80010000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd0, 1, 32'h00003000, 32'hDEADBEEF, 0, 4'h0, 1, 32'h00000000, 3, 32'h3000});
        vq.push_back('{1, 0, 3'd0, 1, 32'h00002FFC, 32'h12345678, 1, 4'hF, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd5, 0, 32'h00002FFC, 32'h00000000, 0, 4'h0, 1, 32'h12345678, 0, 32'h0});
        vq.push_back('{1, 0, 3'd1, 0, 32'h00004000, 32'h00000000, 0, 4'h0, 1, 32'h00000000, 3, 32'h4000});
        vq.push_back('{1, 0, 3'd3, 0, 32'h00003001, 32'h00000000, 0, 4'h0, 1, 32'h00000000, 1, 32'h3001});
        vq.push_back('{1, 0, 3'd6, 0, 32'h00000002, 32'h00000077, 1, 4'h4, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd1, 0, 32'h00000002, 32'h00000000, 0, 4'h0, 1, 32'h00000077, 0, 32'h0});
        vq.push_back('{1, 0, 3'd1, 0, 32'h00000003, 32'h00000000, 0, 4'h0, 1, 32'hFFFFFF80, 0, 32'h0});
        vq.push_back('{1, 0, 3'd0, 0, 32'h00000003, 32'h00000000, 0, 4'h0, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{0, 0, 3'd0, 1, 32'h00000008, 32'h0000AAAA, 0, 4'h0, 0, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 1, 3'd0, 1, 32'h00000008, 32'h00000055, 0, 4'h0, 0, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 1, 3'd5, 0, 32'h00000005, 32'h00000000, 0, 4'h0, 0, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd5, 0, 32'h00000008, 32'h00000000, 0, 4'h0, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd1, 1, 32'h0000000C, 32'hA1B2C3D4, 1, 4'hF, 1, 32'h00000000, 0, 32'h0});
        vq.push_back('{1, 0, 3'd5, 0, 32'h0000000C, 32'h00000000, 0, 4'h0, 1, 32'hA1B2C3D4, 0, 32'h0});
        vq.push_back('{1, 0, 3'd7, 0, 32'h00003FFE, 32'h00001111, 0, 4'h0, 1, 32'h00000000, 3, 32'h3FFE});
        vq.push_back('{1, 0, 3'd4, 0, 32'h00002FFE, 32'h00000000, 0, 4'h0, 1, 32'h00001234, 0, 32'h0});

        // Reset: a pending store must not write, and registers must be clear.
        @(negedge clk);
        #1 chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
        @(posedge clk); #1;
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_rdata_o", rdata_o, 32'd0);
        chk("rst_exc_o", {30'd0, exc_o}, 32'd0);
        chk("rst_badaddr_o", badaddr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].v, vq[i].f, vq[i].op, vq[i].sw, vq[i].addr, vq[i].wd);
            #1;
            chk($sformatf("v%0d_dm_we", i), {31'd0, dm_we}, {31'd0, vq[i].we});
            chk($sformatf("v%0d_dm_be", i), {28'd0, dm_be}, {28'd0, vq[i].be});
            chk($sformatf("v%0d_dm_addr", i), {20'd0, dm_addr}, (vq[i].addr >> 2) & 32'hFFF);
            chk($sformatf("v%0d_dm_din", i), dm_din, vq[i].wd);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_o", i), {31'd0, valid_o}, {31'd0, vq[i].vo});
            chk($sformatf("v%0d_exc_o", i), {30'd0, exc_o}, {30'd0, vq[i].exc});
            chk($sformatf("v%0d_badaddr_o", i), badaddr_o, vq[i].bad);
            if (vq[i].exc == 2'd0)
                chk($sformatf("v%0d_rdata_o", i), rdata_o, vq[i].rd);
        end
        chk("sh_fault_no_write", mem[0], 32'h80770000);
        chk("flush_no_write", mem[2], 32'h00000000);

        // Known faulting load so the frozen register contents are predictable.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd5, 1'b0, 32'h00000005, 32'h0);
        @(posedge clk); #1;
        chk("pre_stall_exc_o", {30'd0, exc_o}, 32'd1);

        // Stall three cycles on an SW (flush on the middle one): no write, outputs frozen.
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(1'b1, (s == 1), 3'd0, 1'b1, 32'h00000010, 32'hCAFEF00D);
            #1 chk($sformatf("stall%0d_dm_we", s), {31'd0, dm_we}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid_o", s), {31'd0, valid_o}, 32'd1);
            chk($sformatf("stall%0d_exc_o", s), {30'd0, exc_o}, 32'd1);
            chk($sformatf("stall%0d_badaddr_o", s), badaddr_o, 32'h5);
        end
        chk("stall_no_write", mem[4], 32'h0);

        // Release: exactly one write, instruction advances.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        #1;
        chk("release_dm_we", {31'd0, dm_we}, 32'd1);
        chk("release_dm_be", {28'd0, dm_be}, 32'hF);
        @(posedge clk); #1;
        chk("release_valid_o", {31'd0, valid_o}, 32'd1);
        chk("release_exc_o", {30'd0, exc_o}, 32'd0);
        chk("release_badaddr_o", badaddr_o, 32'd0);
        chk("release_write", mem[4], 32'hCAFEF00D);

        // Mid-stream reset with a store pending.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'd0, 1'b1, 32'h00000014, 32'h11111111);
        #1 chk("mid_rst_dm_we", {31'd0, dm_we}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_exc_o", {30'd0, exc_o}, 32'd0);
        chk("mid_rst_rdata_o", rdata_o, 32'd0);
        chk("mid_rst_badaddr_o", badaddr_o, 32'd0);
        chk("mid_rst_no_write", mem[5], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DM_WORDS, default 3072, SHALL set the number of implemented data-memory words; word addresses >= DM_WORDS are out of range.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold the MEM/WB register; no store is issued.
REQ-005 flush  input  1  kill the current MEM-stage instruction.
REQ-006 valid_i  input  1  MEM-stage instruction is valid.
REQ-007 op_i  input  3  operation: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH; a separate is_sw_i selects SW.
REQ-008 is_sw_i  input  1  word store; overrides op_i.
REQ-009 addr_i  input  32  effective byte address.
REQ-010 wdata_i  input  32  store data (rt).
REQ-011 dm_dout  input  32  data-memory read word.
REQ-012 dm_addr  output  12  word address, equal to addr_i[13:2].
REQ-013 dm_be  output  4  byte enables.
REQ-014 dm_din  output  32  equal to wdata_i unshifted; the memory places half and byte data in lanes.
REQ-015 dm_we  output  1  store strobe.
REQ-016 rdata_o  output  32  registered, extended load data.
REQ-017 valid_o  output  1  registered instruction-valid to WB.
REQ-018 exc_o  output  2  registered exception: 0 none, 1 AdEL, 2 AdES, 3 out of range.
REQ-019 badaddr_o  output  32  registered faulting addr_i.

Function
REQ-020 Alignment SHALL be checked as follows: a halfword is misaligned if addr_i[0]=1; a word is misaligned if addr_i[1:0]!=0; a byte is never misaligned.
REQ-021 An access SHALL be out of range if addr_i[31:14]!=0 or addr_i[13:2]>=DM_WORDS; misalignment takes priority over range.
REQ-022 For a store, dm_be SHALL be: SW 1111; SH 0011 when addr_i[1]=0, 1100 when addr_i[1]=1; SB 0001/0010/0100/1000 for addr_i[1:0]=0/1/2/3.
REQ-023 dm_we SHALL be 1 only when valid_i=1, a store op is present, stall=0, flush=0, and there is no exception.
REQ-024 dm_be SHALL be 0000 whenever dm_we=0.
REQ-025 Load lane selection (little-endian) SHALL be: byte k = dm_dout[8k+7:8k], half = dm_dout[31:16] when addr_i[1]=1, else dm_dout[15:0].
REQ-026 LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-027 On each edge with stall=0, the MEM/WB register SHALL capture: valid_o=valid_i&~flush, rdata_o=the extended load data (0 for non-loads), exc_o, and badaddr_o (0 when exc=0).
REQ-028 When stall=1, all registered outputs SHALL hold, even when flush=1.
REQ-029 When flush=1 and stall=0, the register SHALL capture valid_o=0, exc_o=0, rdata_o=0, and badaddr_o=0.
REQ-030 An instruction with an exception SHALL still set valid_o=1 so that WB can trap.
REQ-031 Load-to-rdata_o latency SHALL be exactly 1 cycle; the store write occurs on the same edge that advances the instruction.

Reset
REQ-032 When rst=1 at an edge, rdata_o, valid_o, exc_o, and badaddr_o SHALL be cleared to 0; rst overrides stall and flush.
REQ-033 dm_we SHALL be forced to 0 combinationally while rst=1, so that no store happens during reset.
REQ-034 A reset in mid-stream SHALL discard the in-flight instruction with no write.

Verification
REQ-035 Scenario: SB with addr 0x00000003 and wdata 0x000000A5 -> dm_be=1000, dm_we=1, dm_addr=0; a following LBU at 0x3 -> rdata_o=0x000000A5; LB -> 0xFFFFFFA5.
REQ-036 Scenario: SH at 0x2 with 0x00008001, then LH at 0x2 -> dm_be=1100, rdata_o=0xFFFF8001; LHU -> 0x00008001.
REQ-037 Scenario: LW at 0x5 -> dm_we=0, next-cycle exc_o=1 and badaddr_o=0x00000005; SH at 0x1 -> exc_o=2 and memory unchanged.
REQ-038 Scenario: SW at 0x00003000 (word 3072) -> dm_we=0, exc_o=3; SW at 0x00002FFC -> dm_we=1 with dm_addr=0xBFF.
REQ-039 Scenario: stall held for 3 cycles during an SW -> dm_we=0 throughout and outputs frozen; after release, one write occurs and valid_o=1 next cycle.
REQ-040 Scenario: flush with SW valid -> no write, valid_o=0; rst asserted with a store pending -> dm_we=0 and all outputs 0 after the edge.
